// File: rtl/wb_sram_slave.sv
// Wishbone B3 classic SRAM slave with byte lanes and programmable wait states.
// Define WB_SRAM_ERR_EN to add wb_s2m_err and answer out-of-window accesses.
module wb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_m2s_adr,
  input  logic [31:0] wb_m2s_dat,
  input  logic [3:0]  wb_m2s_sel,
  input  logic        wb_m2s_we,
  input  logic        wb_m2s_cyc,
  input  logic        wb_m2s_stb,
  output logic [31:0] wb_s2m_dat,
  output logic        wb_s2m_ack
`ifdef WB_SRAM_ERR_EN
  ,
  output logic        wb_s2m_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

`ifdef WB_SRAM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          err_q;
  logic [31:0]   rdata;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          in_win;
  logic          req;
  logic          go_ack;
  logic          wr;
  logic [AW-1:0] idx_c;
  logic [31:0]   dat_c;
  logic [3:0]    sel_c;
  logic          we_c;
  logic          err_c;
  logic          unused;

  assign unused = ^wb_m2s_adr[1:0];

  assign in_win =
    (wb_m2s_adr[31:2+AW] == BASE_ADDR[31:2+AW]);
  assign req = wb_m2s_cyc & wb_m2s_stb & (in_win | ERR_EN);

  // In IDLE the request comes straight off the bus so that a
  // zero-wait transfer can commit on its accepting edge.
  always_comb begin
    idx_c  = idx_q;
    dat_c  = dat_q;
    sel_c  = sel_q;
    we_c   = we_q;
    err_c  = err_q;
    go_ack = 1'b0;
    case (state)
      IDLE: begin
        idx_c  = wb_m2s_adr[2+AW-1:2];
        dat_c  = wb_m2s_dat;
        sel_c  = wb_m2s_sel;
        we_c   = wb_m2s_we;
        err_c  = ~in_win;
        go_ack = req & NO_WAIT;
      end
      WAIT: go_ack = wb_m2s_cyc & (cnt == 4'd0);
      default: go_ack = 1'b0;
    endcase
  end

  assign wr = go_ack & we_c & ~err_c & ~wb_rst;

  always_ff @(posedge wb_clk) begin
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_c[b]) mem[idx_c][8*b +: 8] <= dat_c[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
      err_q <= 1'b0;
    end else begin
      rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q <= idx_c;
            dat_q <= dat_c;
            sel_q <= sel_c;
            we_q  <= we_c;
            err_q <= err_c;
            if (NO_WAIT) begin
              state <= ACK;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!wb_m2s_cyc) state <= IDLE;
          else if (cnt == 4'd0) state <= ACK;
          else cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
      if (go_ack && !we_c && !err_c) rdata <= mem[idx_c];
    end
  end

  assign wb_s2m_dat = rdata;
  assign wb_s2m_ack = (state == ACK) & ~err_q;

`ifdef WB_SRAM_ERR_EN
  assign wb_s2m_err = (state == ACK) & err_q;
`endif

endmodule
